i2s_sample_tx: RTL
==================

// Module: i2s_sample_tx
// PURPOSE
//  Output end of the audio path: accepts fixed-point samples from effects_pipeline (o_sample) via valid/ready,
//  buffers them in a small FIFO, and serialises them as a Philips-I2S stream (BCLK, LRCLK, SDATA) to the DAC/codec.
//  Generates BCLK/LRCLK from clk. Mono in: the same sample is sent on the left and right slots.
// PARAMETERS
//  fxp_size    16  width of signed fixed-point input sample
//  i2s_word    24  bits per I2S channel slot; must be >= fxp_size
//  bclk_div    4   clk cycles per BCLK half-period; must be >= 2
//  fifo_depth  4   input FIFO entries; power of 2, >= 2
// PORTS
//  clk          in   1         system clock
//  rst          in   1         asynchronous reset, active low
//  i_sample     in   fxp_size  signed sample from effects_pipeline
//  i_valid      in   1         i_sample valid
//  o_ready      out  1         FIFO can accept; a push happens when i_valid & o_ready
//  o_bclk       out  1         I2S bit clock
//  o_lrclk      out  1         I2S word select: 0 = left, 1 = right
//  o_sdata      out  1         I2S serial data, MSB first
//  o_underflow  out  1         1-clk pulse: frame started with FIFO empty
// BEHAVIOUR
//  Reset (rst=0, async)
//   - o_bclk=0, o_lrclk=0, o_sdata=0, o_underflow=0, o_ready=1.
//   - FIFO empty; div_cnt=0; slot_cnt=0; frame_reg=0; shift_reg=0.
//   - Assertion mid-frame aborts the frame immediately. No partial word is resumed.
//  BCLK
//   - div_cnt counts 0..bclk_div-1. On wrap, o_bclk toggles.
//   - Period = 2*bclk_div clk. First rise at clk edge bclk_div after reset release.
//  Slots
//   - On every BCLK falling event (o_bclk 1->0), slot_cnt advances mod 2*i2s_word. Call the new value s.
//   - All serial outputs update only on that clk edge and hold for one BCLK period.
//   - o_lrclk = (s >= i2s_word) ? 1 : 0. It changes one BCLK ahead of the MSB, per I2S.
//  Frame load at s==1 (left MSB)
//   - FIFO non-empty: pop into frame_reg.
//   - FIFO empty: frame_reg holds its last value (0 after reset); o_underflow=1 for exactly that clk.
//   - Then shift_reg <= {frame_reg, (i2s_word-fxp_size) zeros} (left-justified) and o_sdata <= its MSB.
//  Right reload at s==i2s_word+1
//   - shift_reg reloaded from the same frame_reg; no pop.
//  Other slots
//   - shift_reg shifts left one bit; o_sdata <= new MSB.
//   - Slot 0 and slot i2s_word carry the LSB of the preceding channel. Zero padding then yields 0.
//  FIFO
//   - Synchronous, first-word fall-through not required. o_ready = !full, registered from the count.
//   - Push and pop on the same clk: count unchanged, both succeed (pop only when non-empty before the edge).
//   - Push when empty, pop on the same edge: no bypass. The pop sees empty, gives underflow, and the push is stored.
//   - i_sample is ignored when !(i_valid & o_ready). Never overwrite, never drop an accepted sample.
//  Arithmetic
//   - No rescale or rounding; sample bits are passed MSB-aligned. The sign is carried by the MSB (two's complement).
//  Frame period = 2*i2s_word*2*bclk_div clk (384 at defaults). Input sample rate must not exceed this.
// TESTING
//  1 Reset release, no input -> o_bclk toggles every 4 clk; o_lrclk period 384 clk, high 192;
//    o_underflow pulses once per 384 clk; o_sdata=0 throughout.
//  2 Push 0x8001 once -> left slot bits 1..24 = 0x800100 MSB first, right slot identical.
//    The next frame repeats 0x8001 with o_underflow=1.
//  3 Push 0x1234, 0xFEDC, 0x0F0F on consecutive clk -> three consecutive frames carry them in order;
//    no underflow until the 4th frame.
//  4 Hold i_valid=1 from reset with fifo_depth=4 -> 4 accepted before the first pop;
//    o_ready=0 after the 4th; exactly one more accepted per frame thereafter.
//  5 Push at the clk edge of the s==1 load with FIFO empty -> o_underflow=1, old frame sent;
//    the pushed sample goes out in the next frame.
//  6 Assert rst mid right slot, release 10 clk later -> all outputs at reset values;
//    FIFO empty; a fresh frame starts per test 1 timing.

Source files
------------

// File: rtl/i2s_sample_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_sample_tx
// Purpose  : Buffers mono fixed-point samples in a small FIFO and serialises
//            each one on both slots of a Philips-I2S frame (BCLK/LRCLK/SDATA).
// Revision : 1.0 - initial release
// ============================================================================
module i2s_sample_tx #(
  parameter int FXP_SIZE   = 16,
  parameter int I2S_WORD   = 24,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [FXP_SIZE-1:0] i_sample,
  input  logic                i_valid,
  output logic                o_ready,
  output logic                o_bclk,
  output logic                o_lrclk,
  output logic                o_sdata,
  output logic                o_underflow
);

  localparam int c_div_w  = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int c_slots  = 2 * I2S_WORD;
  localparam int c_slot_w = $clog2(c_slots);
  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w  = c_ptr_w + 1;
  localparam int c_pad    = I2S_WORD - FXP_SIZE;

  localparam logic [c_div_w-1:0]  c_div_last   = c_div_w'(BCLK_DIV - 1);
  localparam logic [c_slot_w-1:0] c_slot_last  = c_slot_w'(c_slots - 1);
  localparam logic [c_slot_w-1:0] c_slot_lmsb  = c_slot_w'(1);
  localparam logic [c_slot_w-1:0] c_slot_right = c_slot_w'(I2S_WORD);
  localparam logic [c_slot_w-1:0] c_slot_rmsb  = c_slot_w'(I2S_WORD + 1);
  localparam logic [c_cnt_w-1:0]  c_full       = c_cnt_w'(FIFO_DEPTH);

  logic [c_div_w-1:0]  div_q, div_d;
  logic                bclk_q, bclk_d;
  logic [c_slot_w-1:0] slot_q, slot_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic                underflow_q, underflow_d;
  logic [FXP_SIZE-1:0] frame_q, frame_d;
  logic [I2S_WORD-1:0] shift_q, shift_d;
  logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0]  count_q, count_d;
  logic                ready_q, ready_d;
  logic [FXP_SIZE-1:0] mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic div_wrap;

  assign push = i_valid & ready_q;

  // Bit clock, slot sequencing and serialiser
  always_comb begin
    div_d       = div_q;
    bclk_d      = bclk_q;
    slot_d      = slot_q;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    underflow_d = 1'b0;
    frame_d     = frame_q;
    shift_d     = shift_q;
    pop         = 1'b0;

    div_wrap = (div_q == c_div_last);
    div_d    = div_wrap ? '0 : div_q + c_div_w'(1);
    if (div_wrap) begin
      bclk_d = ~bclk_q;
    end

    // Serial outputs move only on the BCLK falling event
    if (div_wrap && bclk_q) begin
      slot_d  = (slot_q == c_slot_last) ? '0 : slot_q + c_slot_w'(1);
      lrclk_d = (slot_d >= c_slot_right);
      if (slot_d == c_slot_lmsb) begin
        if (count_q != '0) begin
          pop     = 1'b1;
          frame_d = mem_q[rd_ptr_q];
        end else begin
          underflow_d = 1'b1;
        end
        shift_d = I2S_WORD'(frame_d) << c_pad;
      end else if (slot_d == c_slot_rmsb) begin
        shift_d = I2S_WORD'(frame_q) << c_pad;
      end else begin
        shift_d = shift_q << 1;
      end
      sdata_d = shift_d[I2S_WORD-1];
    end
  end

  // FIFO bookkeeping; a pop only ever sees entries stored before this edge
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + c_cnt_w'(1);
      2'b01:   count_d = count_q - c_cnt_w'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != c_full);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q       <= '0;
      bclk_q      <= 1'b0;
      slot_q      <= '0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      underflow_q <= 1'b0;
      frame_q     <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
    end else begin
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      slot_q      <= slot_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      underflow_q <= underflow_d;
      frame_q     <= frame_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= i_sample;
    end
  end

  assign o_ready     = ready_q;
  assign o_bclk      = bclk_q;
  assign o_lrclk     = lrclk_q;
  assign o_sdata     = sdata_q;
  assign o_underflow = underflow_q;

endmodule
`default_nettype wire
